// File: rtl/mhsa_host_pkg.sv
// MHSA host controller shared types and default widths.
// Optional watchdog: define MHSA_HOST_TIMEOUT_EN.
package mhsa_host_pkg;

  localparam int DEF_DATA_W    = 64;
  localparam int DEF_ADDR_W    = 32;
  localparam int DEF_LEN_W     = 16;
  localparam int DEF_ADDR_STEP = 8;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    START,
    WAIT_DONE,
    RD_ISSUE,
    RD_WAIT,
    RD_OUT
  } state_e;

  typedef struct packed {
    logic [DEF_ADDR_W-1:0] in_base;
    logic [DEF_ADDR_W-1:0] out_base;
    logic [DEF_LEN_W-1:0]  in_len;
    logic [DEF_LEN_W-1:0]  out_len;
  } cmd_t;

endpackage

// File: rtl/mhsa_rd_capture.sv
// Read-latency counter and result holding register with valid/ready.
// Optional watchdog in the top: MHSA_HOST_TIMEOUT_EN.
module mhsa_rd_capture
  import mhsa_host_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr_i,
  input  logic              wait_i,
  input  logic              rd_ready,
  input  logic [DATA_W-1:0] soc_data_out,
  output logic              last_o,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data
);

  localparam int CNT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              rd_valid_q, rd_valid_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;

  always_comb begin
    cnt_d      = cnt_q;
    rd_valid_d = rd_valid_q;
    rd_data_d  = rd_data_q;
    last_o     = wait_i && (cnt_q == CNT_W'(RD_LAT - 1));
    if (clr_i) begin
      cnt_d = '0;
    end else if (wait_i) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
    if (last_o) begin
      rd_valid_d = 1'b1;
      rd_data_d  = soc_data_out;
    end else if (rd_valid_q && rd_ready) begin
      rd_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q      <= '0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      cnt_q      <= cnt_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
    end
  end

  assign rd_valid = rd_valid_q;
  assign rd_data  = rd_data_q;

endmodule

// File: rtl/mhsa_host_ctrl.sv
// SoC-side master for the MHSA accelerator: load, start, wait, read back.
// Optional watchdog on done: define MHSA_HOST_TIMEOUT_EN.
module mhsa_host_ctrl
  import mhsa_host_pkg::*;
#(
  parameter int DATA_W      = DEF_DATA_W,
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int LEN_W       = DEF_LEN_W,
  parameter int ADDR_STEP   = DEF_ADDR_STEP,
  parameter int RD_LAT      = 1,
  parameter int TIMEOUT_CYC = 1000000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [ADDR_W-1:0] cmd_in_base,
  input  logic [ADDR_W-1:0] cmd_out_base,
  input  logic [LEN_W-1:0]  cmd_in_len,
  input  logic [LEN_W-1:0]  cmd_out_len,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [DATA_W-1:0] wr_data,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic [DATA_W-1:0] rd_data,
  output logic              busy,
  output logic              job_done,
  output logic              err_timeout,
  output logic              start,
  output logic [ADDR_W-1:0] input_base,
  output logic [ADDR_W-1:0] output_base,
  output logic              soc_write_en,
  output logic [DATA_W-1:0] soc_data_in,
  output logic [ADDR_W-1:0] soc_addr,
  input  logic [DATA_W-1:0] soc_data_out,
  input  logic              done
);

  localparam logic [ADDR_W-1:0] STEP = ADDR_W'(ADDR_STEP);

  state_e            state_q, state_d;
  logic [LEN_W-1:0]  idx_q, idx_d;
  logic [LEN_W-1:0]  in_len_q, in_len_d;
  logic [LEN_W-1:0]  out_len_q, out_len_d;
  logic [ADDR_W-1:0] input_base_q, input_base_d;
  logic [ADDR_W-1:0] output_base_q, output_base_d;
  logic [ADDR_W-1:0] soc_addr_q, soc_addr_d;
  logic [DATA_W-1:0] soc_data_in_q, soc_data_in_d;
  logic              soc_write_en_q, soc_write_en_d;
  logic              start_q, start_d;
  logic              job_done_q, job_done_d;
  logic              cap_last;

`ifdef MHSA_HOST_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
  logic            err_timeout_q, err_timeout_d;
`endif

  always_comb begin
    state_d        = state_q;
    idx_d          = idx_q;
    in_len_d       = in_len_q;
    out_len_d      = out_len_q;
    input_base_d   = input_base_q;
    output_base_d  = output_base_q;
    soc_addr_d     = soc_addr_q;
    soc_data_in_d  = soc_data_in_q;
    soc_write_en_d = 1'b0;
    start_d        = 1'b0;
    job_done_d     = 1'b0;
`ifdef MHSA_HOST_TIMEOUT_EN
    err_timeout_d  = 1'b0;
    to_cnt_d       = (state_q == WAIT_DONE) ? to_cnt_q + TO_W'(1) : '0;
`endif
    unique case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          input_base_d  = cmd_in_base;
          output_base_d = cmd_out_base;
          in_len_d      = cmd_in_len;
          out_len_d     = cmd_out_len;
          idx_d         = '0;
          state_d       = (cmd_in_len != '0) ? LOAD : START;
        end
      end
      LOAD: begin
        if (wr_valid) begin
          soc_write_en_d = 1'b1;
          soc_data_in_d  = wr_data;
          soc_addr_d     = (idx_q == '0) ? input_base_q
                                         : soc_addr_q + STEP;
          if (idx_q == in_len_q - LEN_W'(1)) begin
            idx_d   = '0;
            state_d = START;
          end else begin
            idx_d = idx_q + LEN_W'(1);
          end
        end
      end
      START: begin
        start_d = 1'b1;
        state_d = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (done) begin
          if (out_len_q != '0) begin
            idx_d      = '0;
            soc_addr_d = output_base_q;
            state_d    = RD_ISSUE;
          end else begin
            job_done_d = 1'b1;
            state_d    = IDLE;
          end
        end
`ifdef MHSA_HOST_TIMEOUT_EN
        else if (to_cnt_q == TO_W'(TIMEOUT_CYC - 1)) begin
          err_timeout_d = 1'b1;
          state_d       = IDLE;
        end
`endif
      end
      RD_ISSUE: state_d = RD_WAIT;
      RD_WAIT: begin
        if (cap_last) state_d = RD_OUT;
      end
      RD_OUT: begin
        if (rd_valid && rd_ready) begin
          if (idx_q == out_len_q - LEN_W'(1)) begin
            job_done_d = 1'b1;
            state_d    = IDLE;
          end else begin
            idx_d      = idx_q + LEN_W'(1);
            soc_addr_d = soc_addr_q + STEP;
            state_d    = RD_ISSUE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      idx_q          <= '0;
      in_len_q       <= '0;
      out_len_q      <= '0;
      input_base_q   <= '0;
      output_base_q  <= '0;
      soc_addr_q     <= '0;
      soc_data_in_q  <= '0;
      soc_write_en_q <= 1'b0;
      start_q        <= 1'b0;
      job_done_q     <= 1'b0;
    end else begin
      state_q        <= state_d;
      idx_q          <= idx_d;
      in_len_q       <= in_len_d;
      out_len_q      <= out_len_d;
      input_base_q   <= input_base_d;
      output_base_q  <= output_base_d;
      soc_addr_q     <= soc_addr_d;
      soc_data_in_q  <= soc_data_in_d;
      soc_write_en_q <= soc_write_en_d;
      start_q        <= start_d;
      job_done_q     <= job_done_d;
    end
  end

`ifdef MHSA_HOST_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      to_cnt_q      <= '0;
      err_timeout_q <= 1'b0;
    end else begin
      to_cnt_q      <= to_cnt_d;
      err_timeout_q <= err_timeout_d;
    end
  end

  assign err_timeout = err_timeout_q;
`else
  // No watchdog: constant 0 for any legal (non-negative) limit.
  assign err_timeout = (TIMEOUT_CYC < 0);
`endif

  mhsa_rd_capture #(
    .DATA_W (DATA_W),
    .RD_LAT (RD_LAT)
  ) u_rd_capture (
    .clk          (clk),
    .rst_n        (rst_n),
    .clr_i        (state_q == RD_ISSUE),
    .wait_i       (state_q == RD_WAIT),
    .rd_ready     (rd_ready),
    .soc_data_out (soc_data_out),
    .last_o       (cap_last),
    .rd_valid     (rd_valid),
    .rd_data      (rd_data)
  );

  assign cmd_ready    = (state_q == IDLE);
  assign busy         = (state_q != IDLE);
  assign wr_ready     = (state_q == LOAD);
  assign job_done     = job_done_q;
  assign start        = start_q;
  assign input_base   = input_base_q;
  assign output_base  = output_base_q;
  assign soc_write_en = soc_write_en_q;
  assign soc_data_in  = soc_data_in_q;
  assign soc_addr     = soc_addr_q;

endmodule

// File: tb/tb_mhsa_host_ctrl.sv
// Directed, table-driven bench for mhsa_host_ctrl (RD_LAT=3, TIMEOUT_CYC=50).
// Timeout sequence runs only when MHSA_HOST_TIMEOUT_EN is defined.
module tb_mhsa_host_ctrl;

  localparam int RDL = 3;
  localparam int TO  = 50;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [31:0] cmd_in_base = '0;
  logic [31:0] cmd_out_base = '0;
  logic [15:0] cmd_in_len = '0;
  logic [15:0] cmd_out_len = '0;
  logic        wr_valid = 1'b0;
  logic        wr_ready;
  logic [63:0] wr_data = '0;
  logic        rd_valid;
  logic        rd_ready = 1'b0;
  logic [63:0] rd_data;
  logic        busy, job_done, err_timeout, start;
  logic [31:0] input_base, output_base, soc_addr;
  logic        soc_write_en;
  logic [63:0] soc_data_in;
  logic [63:0] soc_data_out;
  logic        done = 1'b0;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [63:0] mem [logic [31:0]];
  logic [63:0] pipe [RDL];

  mhsa_host_ctrl #(
    .RD_LAT      (RDL),
    .TIMEOUT_CYC (TO)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_in_base  (cmd_in_base),
    .cmd_out_base (cmd_out_base),
    .cmd_in_len   (cmd_in_len),
    .cmd_out_len  (cmd_out_len),
    .wr_valid     (wr_valid),
    .wr_ready     (wr_ready),
    .wr_data      (wr_data),
    .rd_valid     (rd_valid),
    .rd_ready     (rd_ready),
    .rd_data      (rd_data),
    .busy         (busy),
    .job_done     (job_done),
    .err_timeout  (err_timeout),
    .start        (start),
    .input_base   (input_base),
    .output_base  (output_base),
    .soc_write_en (soc_write_en),
    .soc_data_in  (soc_data_in),
    .soc_addr     (soc_addr),
    .soc_data_out (soc_data_out),
    .done         (done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    pipe[0] <= mem.exists(soc_addr) ? mem[soc_addr] : 64'h0;
    for (int i = 1; i < RDL; i++) pipe[i] <= pipe[i-1];
  end
  assign soc_data_out = pipe[RDL-1];

  initial begin
    #500000;
    $display("FAIL global_time_limit reached at cycle %0d", cyc);
    $fatal(1);
  end

  typedef struct {
    logic [31:0] in_base;
    logic [15:0] in_len;
    logic [31:0] out_base;
    logic [15:0] out_len;
    int          wr_gap;
    int          rd_stall;
    int          done_dly;
    bit          stray;
    bit          cmd_busy;
    bit          abort;
    bit          exp_to;
    logic [31:0] last_wr;
    logic [31:0] last_rd;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)",
               name, act, exp, cyc);
    end
  endtask

  function automatic logic [63:0] wdata(input int vi, input int k);
    return 64'hD00D_0000_0000_0000 | (64'(vi) << 32) | 64'(k);
  endfunction

  task automatic run_job(input vec_t v, input int vi);
    int k_wr = 0, k_hs = 0, k_rd = 0;
    int nstart = 0, njob = 0, nto = 0, stall = 0;
    int t_acc, t_start = -1, t_last_hs = -1, t_last_wr = -1;
    int t_done = -1, t_job = -1, t_to = -1, t_prev_rd = -1;
    int c = 0;
    logic [63:0] held = '0;
    logic [31:0] a, last_wr = '0, last_rd = '0;
    bit fin = 0, busy_chk = 0, stray_done = 0, tog = 0;

    for (int i = 0; i < int'(v.out_len); i++)
      mem[v.out_base + 32'(i) * 8] =
        64'hA5A5_0000_0000_0000 ^ (64'(vi) << 16) ^ 64'(i);

    @(negedge clk);
    chk("cmd_ready_idle", {63'd0, cmd_ready}, 64'd1);
    cmd_valid    = 1'b1;
    cmd_in_base  = v.in_base;
    cmd_out_base = v.out_base;
    cmd_in_len   = v.in_len;
    cmd_out_len  = v.out_len;
    t_acc = cyc;
    @(negedge clk);
    cmd_valid = 1'b0;

    while (!fin) begin
      if (soc_write_en) begin
        a = v.in_base + 32'(k_wr) * 8;
        chk("wr_addr", {32'd0, soc_addr}, {32'd0, a});
        chk("wr_data", soc_data_in, wdata(vi, k_wr));
        mem[soc_addr] = soc_data_in;
        last_wr   = soc_addr;
        t_last_wr = cyc;
        k_wr++;
      end
      if (start) begin
        nstart++;
        t_start = cyc;
        chk("input_base", {32'd0, input_base}, {32'd0, v.in_base});
        chk("output_base", {32'd0, output_base}, {32'd0, v.out_base});
      end
      if (job_done) begin
        njob++;
        t_job = cyc;
        chk("busy_after_job", {63'd0, busy}, 64'd0);
        fin = 1;
      end
      if (err_timeout) begin
        nto++;
        t_to = cyc;
        chk("busy_after_to", {63'd0, busy}, 64'd0);
        fin = 1;
      end

      done = 1'b0;
      if (!v.exp_to && t_start >= 0 && cyc == t_start + v.done_dly) begin
        done   = 1'b1;
        t_done = cyc;
      end else if (v.stray && !stray_done && wr_ready) begin
        done       = 1'b1;
        stray_done = 1;
      end

      cmd_valid = 1'b0;
      if (v.cmd_busy && t_start >= 0 && cyc < t_start + v.done_dly) begin
        cmd_valid    = 1'b1;
        cmd_in_base  = 32'hDEAD_0000;
        cmd_out_base = 32'hBEEF_0000;
        cmd_in_len   = 16'd7;
        if (!busy_chk) begin
          chk("cmd_ready_busy", {63'd0, cmd_ready}, 64'd0);
          busy_chk = 1;
        end
      end

      tog = !tog;
      wr_valid = 1'b0;
      if (k_hs < int'(v.in_len)) begin
        wr_valid = (v.wr_gap == 0) ? 1'b1 : tog;
        wr_data  = wdata(vi, k_hs);
        if (wr_valid && wr_ready) begin
          t_last_hs = cyc;
          k_hs++;
        end
      end

      rd_ready = 1'b0;
      if (rd_valid && v.abort) begin
        fin = 1;
      end else if (rd_valid) begin
        a = v.out_base + 32'(k_rd) * 8;
        if (stall < v.rd_stall) begin
          if (stall == 0) held = rd_data;
          else chk("rd_stable", rd_data, held);
          chk("rd_addr_hold", {32'd0, soc_addr}, {32'd0, a});
          stall++;
        end else begin
          rd_ready = 1'b1;
          chk("rd_addr", {32'd0, soc_addr}, {32'd0, a});
          chk("rd_data", rd_data, mem[a]);
          if (v.rd_stall > 0) chk("rd_stable_hs", rd_data, held);
          if (v.rd_stall == 0 && t_prev_rd >= 0)
            chk("rd_period", 64'(cyc - t_prev_rd), 64'(RDL + 2));
          if (v.cmd_busy && k_rd == 0)
            chk("in_base_hold", {32'd0, input_base}, {32'd0, v.in_base});
          t_prev_rd = cyc;
          last_rd   = soc_addr;
          stall     = 0;
          k_rd++;
        end
      end

      c++;
      if (!fin && c > 3000) begin
        checks++;
        errors++;
        $display("FAIL job%0d_budget: no completion after %0d cycles", vi, c);
        fin = 1;
      end
      if (!fin) @(negedge clk);
    end

    if (v.abort) return;

    wr_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      rd_ready = 1'b0;
      done     = 1'b0;
      if (job_done) njob++;
      if (err_timeout) nto++;
      if (start) nstart++;
      if (soc_write_en) k_wr++;
    end

    chk("n_wr", 64'(k_wr), 64'(v.in_len));
    chk("n_start", 64'(nstart), 64'd1);
    if (v.in_len != 0) begin
      chk("last_wr_addr", {32'd0, last_wr}, {32'd0, v.last_wr});
      chk("start_lat", 64'(t_start), 64'(t_last_hs + 2));
      chk("start_after_wr", 64'(t_start), 64'(t_last_wr + 1));
    end else begin
      chk("start_lat0", 64'(t_start), 64'(t_acc + 2));
    end
    if (v.exp_to) begin
      chk("to_cycle", 64'(t_to), 64'(t_start + TO));
      chk("n_to", 64'(nto), 64'd1);
      chk("n_job_to", 64'(njob), 64'd0);
      chk("n_rd_to", 64'(k_rd), 64'd0);
    end else begin
      chk("n_job", 64'(njob), 64'd1);
      chk("n_to0", 64'(nto), 64'd0);
      chk("n_rd", 64'(k_rd), 64'(v.out_len));
      if (v.out_len != 0)
        chk("last_rd_addr", {32'd0, last_rd}, {32'd0, v.last_rd});
      else
        chk("job_lat0", 64'(t_job), 64'(t_done + 1));
    end
  endtask

  vec_t vecs[6];
  vec_t vx;

  initial begin
    vecs[0] = '{32'h1000, 16'd4, 32'h2000, 16'd2, 0, 0, 10,
                0, 0, 0, 0, 32'h1018, 32'h2008};
    vecs[1] = '{32'h3000, 16'd0, 32'h4000, 16'd0, 0, 0, 10,
                0, 0, 0, 0, 32'h0, 32'h0};
    vecs[2] = '{32'h5000, 16'd3, 32'h6000, 16'd3, 1, 5, 10,
                1, 0, 0, 0, 32'h5010, 32'h6010};
    vecs[3] = '{32'h7000, 16'd2, 32'h8000, 16'd1, 0, 0, 10,
                0, 1, 0, 0, 32'h7008, 32'h8000};
    vecs[4] = '{32'hFFFF_FFF0, 16'd3, 32'hFFFF_FFF8, 16'd2, 0, 0, 10,
                0, 0, 0, 0, 32'h0, 32'h0};
    vecs[5] = '{32'h0100, 16'd1, 32'h0200, 16'd0, 0, 0, 10,
                0, 0, 0, 0, 32'h0100, 32'h0};

    #2;
    chk("rst_cmd_ready", {63'd0, cmd_ready}, 64'd1);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_start", {63'd0, start}, 64'd0);
    chk("rst_rd_valid", {63'd0, rd_valid}, 64'd0);
    chk("rst_wr_en", {63'd0, soc_write_en}, 64'd0);
    chk("rst_addr", {32'd0, soc_addr}, 64'd0);
    chk("rst_job_done", {63'd0, job_done}, 64'd0);
    chk("rst_err_to", {63'd0, err_timeout}, 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 6; i++) run_job(vecs[i], i);

    vx = vecs[0];
    vx.abort = 1;
    vx.rd_stall = 100;
    run_job(vx, 6);
    chk("pre_rst_rd_valid", {63'd0, rd_valid}, 64'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_rd_valid", {63'd0, rd_valid}, 64'd0);
    chk("mid_rst_rd_data", rd_data, 64'd0);
    chk("mid_rst_busy", {63'd0, busy}, 64'd0);
    chk("mid_rst_addr", {32'd0, soc_addr}, 64'd0);
    chk("mid_rst_out_base", {32'd0, output_base}, 64'd0);
    chk("mid_rst_cmd_ready", {63'd0, cmd_ready}, 64'd1);
    @(negedge clk);
    rst_n = 1'b1;
    run_job(vecs[0], 7);

`ifdef MHSA_HOST_TIMEOUT_EN
    vx = '{32'hB000, 16'd0, 32'hC000, 16'd2, 0, 0, 0,
           0, 0, 0, 1, 32'h0, 32'h0};
    run_job(vx, 8);
`else
    vx = '{32'h9000, 16'd1, 32'hA000, 16'd1, 0, 0, 80,
           0, 0, 0, 0, 32'h9000, 32'hA000};
    run_job(vx, 8);
`endif
    run_job(vecs[2], 9);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
